// File: rtl/clock_rate_monitor.sv
// Measures the rate of an asynchronous clock by counting its rising edges over a
// fixed window of sclk cycles, and tracks lock/fault status from successive windows.
module clock_rate_monitor #(
  parameter int WINDOW       = 1024,
  parameter int EXP_COUNT    = 256,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             mon_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam int WIN_W = $clog2(WINDOW);
  localparam int GC_W  = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_WINDOWS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Lower bound clamps at zero so a large tolerance cannot wrap around.
  localparam int LO = (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0;
  localparam int HI = EXP_COUNT + TOL;

  logic [2:0]       sync_q;
  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [GC_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             locked_q, fault_q;

  logic             mon_rise;
  logic             terminal;
  logic [CNT_W-1:0] total;
  logic [31:0]      total_ext;
  logic             good;

  assign mon_rise  = sync_q[1] & ~sync_q[2];
  assign terminal  = (win_q == WIN_LAST);
  assign total     = (edge_q == CNT_MAX) ? CNT_MAX : edge_q + {{(CNT_W-1){1'b0}}, mon_rise};
  assign total_ext = 32'(total);
  assign good      = (total_ext >= 32'(LO)) && (total_ext <= 32'(HI));

  // count_valid is a single-cycle strobe with no back-pressure: count is
  // stable from the strobe cycle until the next strobe.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    edge_d  = edge_q;
    good_d  = good_q;
    count_d = count_q;
    valid_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      win_d   = '0;
      edge_d  = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          win_d   = '0;
          edge_d  = '0;
          good_d  = '0;
        end
        ST_ACQ, ST_LOCKED: begin
          if (terminal) begin
            win_d   = '0;
            edge_d  = '0;
            count_d = total;
            valid_d = 1'b1;
            if (state_q == ST_ACQ) begin
              if (!good) begin
                good_d = '0;
              end else if (good_q == GC_LAST) begin
                good_d  = '0;
                state_d = ST_LOCKED;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else if (!good) begin
              state_d = ST_FAULT;
            end
          end else begin
            win_d  = win_q + 1'b1;
            edge_d = total;
          end
        end
        default: begin
          win_d  = '0;
          edge_d = '0;
          good_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      win_q    <= '0;
      edge_q   <= '0;
      good_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], mon_clk};
      state_q  <= state_d;
      win_q    <= win_d;
      edge_q   <= edge_d;
      good_q   <= good_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      locked_q <= (state_d == ST_LOCKED);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign locked      = locked_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: doc/clock_rate_monitor.md
CLOCK_RATE_MONITOR -- requirements
Module: clock_rate_monitor

Interface
REQ-001 Parameter WINDOW, default 1024, sets the number of sclk cycles per measurement window (>=4).
REQ-002 Parameter EXP_COUNT, default 256, sets the expected mon_clk rising edges per window.
REQ-003 Parameter TOL, default 2, sets the allowed |count-EXP_COUNT| for a good window.
REQ-004 Parameter LOCK_WINDOWS, default 4, sets the consecutive good windows required to lock (>=1).
REQ-005 Parameter CNT_W, default 16, sets the width of the edge count.
REQ-006 sclk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 mon_clk  in  1  monitored clock, asynchronous to sclk, sampled as data.
REQ-009 enable  in  1  high = measure; low = return to IDLE.
REQ-010 count  out  CNT_W  edge count of the last completed window.
REQ-011 count_valid  out  1  one-cycle pulse when count updates.
REQ-012 locked  out  1  high while in LOCKED.
REQ-013 fault  out  1  high while in FAULT.
REQ-014 state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.

Function
REQ-015 mon_clk SHALL pass through a 3-flop synchronizer; a rising edge is sync[1]=1 and sync[2]=0, one cycle per edge.
REQ-016 Correct counting SHALL be guaranteed only for mon_clk high and low phases each >=2 sclk periods; faster input is out of scope.
REQ-017 In IDLE, the window counter, edge counter and good-window counter SHALL be held at 0 and edges ignored; the synchronizer keeps running.
REQ-018 IDLE->ACQUIRE SHALL occur on the first cycle enable=1 is sampled; the window counter is 0 in the first ACQUIRE cycle.
REQ-019 In ACQUIRE/LOCKED the window counter SHALL count 0..WINDOW-1 and wrap to 0; cycle WINDOW-1 is the terminal cycle.
REQ-020 On the terminal cycle, count SHALL be loaded with edge_cnt plus the terminal-cycle edge; edge_cnt clears to 0; count and count_valid are visible the following cycle.
REQ-021 edge_cnt and the loaded count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-022 A window SHALL be good iff EXP_COUNT-TOL <= count <= EXP_COUNT+TOL, evaluated on the terminal-cycle value, with no underflow when TOL>EXP_COUNT.
REQ-023 ACQUIRE: a good window increments good_cnt; reaching LOCK_WINDOWS enters LOCKED the cycle after the terminal cycle; a bad window clears good_cnt and stays in ACQUIRE.
REQ-024 LOCKED: good windows keep LOCKED; one bad window enters FAULT the cycle after the terminal cycle.
REQ-025 FAULT SHALL be sticky: counting stops, count holds, count_valid stays 0 until enable=0.
REQ-026 enable=0 in any state SHALL enter IDLE next cycle; a window in progress is discarded with no count_valid pulse; count holds its last value.
REQ-027 enable=0 on a terminal cycle SHALL take priority: no count_valid, no state update from that window.
REQ-028 locked and fault SHALL be registered decodes of state, changing in the same cycle as state.

Reset
REQ-029 reset_n=0 at a rising sclk edge SHALL force state=IDLE, count=0, count_valid=0, locked=0, fault=0, zero all counters and synchronizer flops, overriding all other inputs, including mid-window and in FAULT.
REQ-030 After reset_n returns high, operation SHALL resume per REQ-018 with no residual window data.

Verification (bench parameters WINDOW=16, EXP_COUNT=4, TOL=1, LOCK_WINDOWS=2, CNT_W=8)
REQ-031 mon_clk period 4 sclk, enable=1 -> count=4 with count_valid every 16 cycles; state ACQ->LOCKED after the 2nd window; locked=1.
REQ-032 Locked, then mon_clk period 8 sclk -> next full window count=2, state=FAULT, fault=1, no further count_valid; enable=0 -> IDLE next cycle, fault=0.
REQ-033 ACQUIRE: good, bad (count=6), good, good windows -> LOCKED only after the 4th window (good_cnt cleared by the bad one).
REQ-034 mon_clk constant 0 for a window -> count=0 (no underflow in range check), ACQUIRE retained; rising edge aligned to terminal cycle -> counted in the closing window.
REQ-035 reset_n=0 for 1 cycle mid-window while LOCKED -> next cycle all outputs 0, state=IDLE; enable held 1 -> ACQUIRE, first count_valid 16 cycles later.
REQ-036 enable dropped on a terminal cycle -> no count_valid, count unchanged, state=IDLE next cycle.
